mac_accum_ctrl: RTL and testbench
=================================

# mac_accum_ctrl

Sequencing controller for the four-lane MAC multiply datapath. It takes a job descriptor (mode and beat count), streams operand beats into the multiplier, registers each product and accumulates it, then returns one accumulated result per job. It sits between the operand-fetch logic and the multiply datapath, and is the only block that drives the datapath's operand and config inputs.

## Interface
- `ACC_W`, 48: accumulator width; must be ≥ `MAC_INT_WIDTH`.
- `LEN_W`, 16: width of the beat count.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `en` in 1: global enable; low freezes all state.
- `cfg_valid` in 1, `cfg_ready` out 1: job-descriptor handshake.
- `cfg_mode` in `MAC_CONF_WIDTH`: `MAC_SINGLE`, `MAC_DUAL` or `MAC_QUAD`.
- `cfg_len` in `LEN_W`: number of operand beats in the job.
- `in_valid` in 1, `in_ready` out 1: operand-beat handshake.
- `in_a` in 4×`MAC_MIN_WIDTH`: lanes {A3,A2,A1,A0}, with A0 in the LSBs.
- `in_b` in `MAC_MIN_WIDTH`: B operand.
- `mul_a0`..`mul_a3` out `MAC_MIN_WIDTH` each, `mul_b` out `MAC_MIN_WIDTH`, `mul_cfg` out `MAC_CONF_WIDTH`: drive the datapath.
- `mul_c` in `MAC_INT_WIDTH`: combinational product returned by the datapath.
- `out_valid` in/out: `out_valid` out 1, `out_ready` in 1: result handshake.
- `out_acc` out `ACC_W`: accumulated result.
- `out_err` out 1: job carried an invalid mode.
- `busy` out 1: FSM is not in IDLE.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - `cfg_ready`=1.
  - On `cfg_valid`, latch mode and len and clear the accumulator.
  - len=0 → DONE with `out_acc`=0.
  - Invalid mode → DONE with `out_acc`=0, `out_err`=1; no beats consumed.
  - Otherwise → RUN.
- RUN:
  - `in_ready`=1 while beats remain.
  - Each `in_valid`&`in_ready` beat registers the operands onto the `mul_*` outputs and decrements the remaining count.
  - The last beat accepted → DRAIN.
- Lane gating from the latched mode:
  - SINGLE drives only `mul_a3`.
  - DUAL drives `mul_a2`/`mul_a3`.
  - QUAD drives all four lanes.
  - Unused lanes are driven to 0.
- Product stage: the cycle after a beat is presented, `mul_c` is captured into the product register and the valid bit is piped alongside it.
- Accumulate stage: acc += zero-extended product register, modulo 2^`ACC_W` (wraps, no saturation). Unsigned arithmetic throughout.
- DRAIN: wait until the pipe valid bits are clear, then → DONE.
- DONE:
  - `out_valid`=1; `out_acc` and `out_err` are held stable until `out_ready`.
  - On `out_ready`, → IDLE.
- `en`=0:
  - Stalls the FSM, counters, pipe and accumulator.
  - Forces `cfg_ready`=`in_ready`=0.
  - `out_valid` and the outputs hold their current values.
- `cfg_valid` outside IDLE is ignored; `cfg_ready`=0.

## Timing
- Reset values: every output is 0, including `mul_*` outputs, `out_acc` and `busy`. FSM=IDLE, pipe valid bits cleared.
- Reset asserted mid-job abandons the job. No partial result is emitted after reset.
- Beat accepted in cycle t:
  - operands on `mul_*` in t+1;
  - product registered at the end of t+1;
  - accumulated at the end of t+2.
- Throughput: 1 beat/cycle; `in_valid` gaps are tolerated.
- Result latency: the last beat accepted in cycle t → `out_valid` high in t+3.
- len=0 or an invalid mode: cfg accepted in cycle t → `out_valid` in t+1.
- The `out_ready` cycle: `busy` drops the next cycle, and `cfg_ready` rises in that same next cycle. There is no same-cycle result/config overlap.
- `mul_cfg` is registered at the cfg handshake and stays stable for the whole job.

## Structure
- Shared header `mac_const.vh` owns:
  - `MAC_MIN_WIDTH`, `MAC_CONF_WIDTH`, `MAC_INT_WIDTH`, `MAC_MULT_WIDTH`;
  - `MAC_SINGLE`/`MAC_DUAL`/`MAC_QUAD`;
  - the new FSM state encodings `MAC_ACC_IDLE`/`RUN`/`DRAIN`/`DONE`.
- One sub-module, `mac_acc_pipe`: the two-stage product/accumulate pipe. Ports: valid-in, `mul_c`, clear, `en`; outputs acc and pipe-busy.
- The FSM, counter and lane gating live in the top level.
- The multiply datapath is instantiated by the parent, not inside this block.

## Test plan
- SINGLE, len=3, A3=3,5,7, B=2,4,6, back-to-back beats → `out_acc`=68, `out_valid` 3 cycles after the last beat; `mul_a0..a2` stay 0.
- QUAD, len=2, `in_a`=0x01020304 and 0x00000010, B=2 and 3 → `out_acc`=0x02040608+0x30=0x02040638; `mul_cfg`=`MAC_QUAD` throughout.
- DUAL, len=2 with a 2-cycle `in_valid` gap, A={A3=0x01,A2=0xFF}, B=0x10 both beats → `out_acc`=2×0x1FF0=0x3FE0; `in_ready` drops after the 2nd beat.
- len=0 → `out_valid` the next cycle with `out_acc`=0; invalid mode 2'b11 → `out_err`=1, `in_ready` never asserts.
- `out_ready` held low 5 cycles, then `en` low 3 cycles mid-RUN → result held stable; the stalled job completes with the correct sum, 3 cycles later than without the stall.
- `rst` pulsed after beat 2 of a len=4 job → all outputs 0 immediately; the next job (SINGLE, len=1, 9×9) → `out_acc`=81.

Source files
------------

// File: rtl/mac_accum_ctrl_pkg.sv
// Shared constants, state encoding and lane helpers for the MAC accumulate controller.
package mac_accum_ctrl_pkg;

  localparam int MAC_MIN_WIDTH  = 8;
  localparam int MAC_CONF_WIDTH = 2;
  localparam int MAC_MULT_WIDTH = 4 * MAC_MIN_WIDTH;
  localparam int MAC_INT_WIDTH  = MAC_MULT_WIDTH + MAC_MIN_WIDTH;

  localparam logic [MAC_CONF_WIDTH-1:0] MAC_SINGLE = 2'd0;
  localparam logic [MAC_CONF_WIDTH-1:0] MAC_DUAL   = 2'd1;
  localparam logic [MAC_CONF_WIDTH-1:0] MAC_QUAD   = 2'd2;

  typedef enum logic [1:0] {
    MAC_ACC_IDLE  = 2'd0,
    MAC_ACC_RUN   = 2'd1,
    MAC_ACC_DRAIN = 2'd2,
    MAC_ACC_DONE  = 2'd3
  } mac_acc_state_e;

  function automatic logic mode_is_valid(input logic [MAC_CONF_WIDTH-1:0] mode);
    return (mode == MAC_SINGLE) || (mode == MAC_DUAL) || (mode == MAC_QUAD);
  endfunction

  // Narrow modes occupy the top lanes; lanes a mode does not use read as zero.
  function automatic logic [MAC_MULT_WIDTH-1:0] gate_lanes(
    input logic [MAC_CONF_WIDTH-1:0] mode,
    input logic [MAC_MULT_WIDTH-1:0] a
  );
    logic [MAC_MULT_WIDTH-1:0] g;
    g = '0;
    case (mode)
      MAC_SINGLE: g[MAC_MULT_WIDTH-1 -: MAC_MIN_WIDTH]     = a[MAC_MULT_WIDTH-1 -: MAC_MIN_WIDTH];
      MAC_DUAL:   g[MAC_MULT_WIDTH-1 -: 2*MAC_MIN_WIDTH]   = a[MAC_MULT_WIDTH-1 -: 2*MAC_MIN_WIDTH];
      MAC_QUAD:   g                                        = a;
      default:    g                                        = '0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/mac_accum_ctrl_if.sv
// Job-descriptor, operand-beat, datapath and result signals of the MAC accumulate controller.
interface mac_accum_ctrl_if
  import mac_accum_ctrl_pkg::*;
#(
  parameter int ACC_W = 48,
  parameter int LEN_W = 16
);
  logic                      cfg_valid;
  logic                      cfg_ready;
  logic [MAC_CONF_WIDTH-1:0] cfg_mode;
  logic [LEN_W-1:0]          cfg_len;

  logic                      in_valid;
  logic                      in_ready;
  logic [MAC_MULT_WIDTH-1:0] in_a;
  logic [MAC_MIN_WIDTH-1:0]  in_b;

  logic [MAC_MIN_WIDTH-1:0]  mul_a0;
  logic [MAC_MIN_WIDTH-1:0]  mul_a1;
  logic [MAC_MIN_WIDTH-1:0]  mul_a2;
  logic [MAC_MIN_WIDTH-1:0]  mul_a3;
  logic [MAC_MIN_WIDTH-1:0]  mul_b;
  logic [MAC_CONF_WIDTH-1:0] mul_cfg;
  logic [MAC_INT_WIDTH-1:0]  mul_c;

  logic                      out_valid;
  logic                      out_ready;
  logic [ACC_W-1:0]          out_acc;
  logic                      out_err;
  logic                      busy;

  modport slave (
    input  cfg_valid, cfg_mode, cfg_len, in_valid, in_a, in_b, mul_c, out_ready,
    output cfg_ready, in_ready, mul_a0, mul_a1, mul_a2, mul_a3, mul_b, mul_cfg,
           out_valid, out_acc, out_err, busy
  );

  modport master (
    output cfg_valid, cfg_mode, cfg_len, in_valid, in_a, in_b, mul_c, out_ready,
    input  cfg_ready, in_ready, mul_a0, mul_a1, mul_a2, mul_a3, mul_b, mul_cfg,
           out_valid, out_acc, out_err, busy
  );

endinterface

// File: rtl/mac_accum_ctrl_acc_pipe.sv
// Two-stage product/accumulate pipe: registers the datapath product, then adds it
// into a wrapping unsigned accumulator.
module mac_acc_pipe
  import mac_accum_ctrl_pkg::*;
#(
  parameter int ACC_W = 48
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     i_vld,
  input  logic [MAC_INT_WIDTH-1:0] i_mul_c,
  input  logic                     i_clr,
  output logic [ACC_W-1:0]         o_acc,
  output logic                     o_busy
);

  logic                     r_vld_p0;
  logic                     r_vld_p1;
  logic [MAC_INT_WIDTH-1:0] r_prod_p1;
  logic [ACC_W-1:0]         r_acc_p2;

  function automatic logic [ACC_W-1:0] acc_add(
    input logic [ACC_W-1:0]         acc,
    input logic [MAC_INT_WIDTH-1:0] prod
  );
    return acc + ACC_W'(prod);
  endfunction

  // p0: operands are on the datapath; p1: product captured from mul_c
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p0  <= 1'b0;
      r_vld_p1  <= 1'b0;
      r_prod_p1 <= '0;
    end else if (en) begin
      r_vld_p0 <= i_vld;
      r_vld_p1 <= r_vld_p0;
      if (r_vld_p0)
        r_prod_p1 <= i_mul_c;
    end
  end

  // p2: accumulate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc_p2 <= '0;
    end else if (en) begin
      if (i_clr)
        r_acc_p2 <= '0;
      else if (r_vld_p1)
        r_acc_p2 <= acc_add(r_acc_p2, r_prod_p1);
    end
  end

  // The product stage always retires on the next enabled edge, so only beats
  // that have not reached it yet keep the pipe busy.
  assign o_busy = i_vld | r_vld_p0;
  assign o_acc  = r_acc_p2;

endmodule

// File: rtl/mac_accum_ctrl.sv
// Sequencing controller for the four-lane MAC datapath: accepts a job, streams
// gated operand beats to the multiplier and returns one accumulated result.
module mac_accum_ctrl
  import mac_accum_ctrl_pkg::*;
#(
  parameter int ACC_W = 48,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  mac_accum_ctrl_if.slave  bus
);

  mac_acc_state_e            r_state;
  mac_acc_state_e            w_state_nxt;
  logic [LEN_W-1:0]          r_remain;
  logic [MAC_CONF_WIDTH-1:0] r_mode;
  logic                      r_err;
  logic [MAC_MULT_WIDTH-1:0] r_lanes;
  logic [MAC_MIN_WIDTH-1:0]  r_b;

  logic                      w_cfg_ready;
  logic                      w_in_ready;
  logic                      w_cfg_fire;
  logic                      w_in_fire;
  logic                      w_cfg_bad;
  logic                      w_pipe_busy;
  logic [ACC_W-1:0]          w_acc;

  assign w_cfg_fire = bus.cfg_valid & w_cfg_ready;
  assign w_in_fire  = bus.in_valid & w_in_ready;
  assign w_cfg_bad  = !mode_is_valid(bus.cfg_mode);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= MAC_ACC_IDLE;
    else if (en)
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MAC_ACC_IDLE:
        if (w_cfg_fire)
          w_state_nxt = (w_cfg_bad || bus.cfg_len == '0) ? MAC_ACC_DONE : MAC_ACC_RUN;
      MAC_ACC_RUN:
        if (w_in_fire && r_remain == LEN_W'(1))
          w_state_nxt = MAC_ACC_DRAIN;
      MAC_ACC_DRAIN:
        if (!w_pipe_busy)
          w_state_nxt = MAC_ACC_DONE;
      MAC_ACC_DONE:
        if (bus.out_ready)
          w_state_nxt = MAC_ACC_IDLE;
      default:
        w_state_nxt = MAC_ACC_IDLE;
    endcase
  end

  // cfg_ready is also held low while reset is asserted so every output reads zero.
  always_comb begin
    w_cfg_ready   = en && !rst && (r_state == MAC_ACC_IDLE);
    w_in_ready    = en && (r_state == MAC_ACC_RUN) && (r_remain != '0);
    bus.out_valid = (r_state == MAC_ACC_DONE);
    bus.busy      = (r_state != MAC_ACC_IDLE);
  end

  assign bus.cfg_ready = w_cfg_ready;
  assign bus.in_ready  = w_in_ready;

  // Job descriptor latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode   <= '0;
      r_err    <= 1'b0;
      r_remain <= '0;
    end else if (en) begin
      if (w_cfg_fire) begin
        r_mode   <= bus.cfg_mode;
        r_err    <= w_cfg_bad;
        r_remain <= bus.cfg_len;
      end else if (w_in_fire) begin
        r_remain <= r_remain - LEN_W'(1);
      end
    end
  end

  // Operand stage: gated lanes presented to the datapath the cycle after acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lanes <= '0;
      r_b     <= '0;
    end else if (en && w_in_fire) begin
      r_lanes <= gate_lanes(r_mode, bus.in_a);
      r_b     <= bus.in_b;
    end
  end

  mac_acc_pipe #(
    .ACC_W (ACC_W)
  ) u_pipe (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .i_vld   (w_in_fire),
    .i_mul_c (bus.mul_c),
    .i_clr   (w_cfg_fire),
    .o_acc   (w_acc),
    .o_busy  (w_pipe_busy)
  );

  assign bus.mul_a0  = r_lanes[0*MAC_MIN_WIDTH +: MAC_MIN_WIDTH];
  assign bus.mul_a1  = r_lanes[1*MAC_MIN_WIDTH +: MAC_MIN_WIDTH];
  assign bus.mul_a2  = r_lanes[2*MAC_MIN_WIDTH +: MAC_MIN_WIDTH];
  assign bus.mul_a3  = r_lanes[3*MAC_MIN_WIDTH +: MAC_MIN_WIDTH];
  assign bus.mul_b   = r_b;
  assign bus.mul_cfg = r_mode;
  assign bus.out_acc = w_acc;
  assign bus.out_err = r_err;

endmodule

// File: tb/tb_mac_accum_ctrl.sv
// Directed bench for mac_accum_ctrl with a mode-aware behavioural multiply datapath.
module tb_mac_accum_ctrl;
  import mac_accum_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic en;
  int   errors = 0;
  int   checks = 0;
  int   cyc;

  mac_accum_ctrl_if #(.ACC_W(48), .LEN_W(16)) bif ();

  mac_accum_ctrl #(.ACC_W(48), .LEN_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (bif)
  );

  always #5 clk = ~clk;

  function automatic logic [MAC_INT_WIDTH-1:0] dp_model(
    input logic [1:0] cfg,
    input logic [7:0] a3, a2, a1, a0, b
  );
    logic [MAC_INT_WIDTH-1:0] bb;
    bb = MAC_INT_WIDTH'(b);
    case (cfg)
      MAC_SINGLE: return MAC_INT_WIDTH'(a3) * bb;
      MAC_DUAL:   return MAC_INT_WIDTH'({a3, a2}) * bb;
      MAC_QUAD:   return MAC_INT_WIDTH'({a3, a2, a1, a0}) * bb;
      default:    return '0;
    endcase
  endfunction

  assign bif.mul_c = dp_model(bif.mul_cfg, bif.mul_a3, bif.mul_a2, bif.mul_a1, bif.mul_a0, bif.mul_b);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic cfg(input logic [1:0] mode, input logic [15:0] len);
    bif.cfg_valid = 1'b1;
    bif.cfg_mode  = mode;
    bif.cfg_len   = len;
    tick();
    bif.cfg_valid = 1'b0;
  endtask

  task automatic beat(input logic [31:0] a, input logic [7:0] b);
    bif.in_valid = 1'b1;
    bif.in_a     = a;
    bif.in_b     = b;
    tick();
    bif.in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    while (!bif.out_valid && n < 30) begin
      tick();
      n++;
    end
    chk(tag, 64'(bif.out_valid), 64'd1);
  endtask

  task automatic release_out();
    bif.out_ready = 1'b1;
    tick();
    bif.out_ready = 1'b0;
  endtask

  initial begin
    int c0;
    cyc = 0;
    rst = 1'b1;
    en  = 1'b1;
    bif.cfg_valid = 1'b0; bif.cfg_mode = '0; bif.cfg_len = '0;
    bif.in_valid  = 1'b0; bif.in_a = '0;    bif.in_b = '0;
    bif.out_ready = 1'b0;
    tick(); tick();

    chk("rst_out_valid", 64'(bif.out_valid), 64'd0);
    chk("rst_out_acc",   64'(bif.out_acc),   64'd0);
    chk("rst_busy",      64'(bif.busy),      64'd0);
    chk("rst_cfg_ready", 64'(bif.cfg_ready), 64'd0);
    chk("rst_mul",       64'({bif.mul_a3, bif.mul_a2, bif.mul_a1, bif.mul_a0, bif.mul_b, bif.mul_cfg}), 64'd0);
    rst = 1'b0;
    tick();
    chk("idle_cfg_ready", 64'(bif.cfg_ready), 64'd1);

    // SINGLE len=3, back-to-back: 3*2 + 5*4 + 7*6 = 68
    cfg(MAC_SINGLE, 16'd3);
    chk("s_busy", 64'(bif.busy), 64'd1);
    beat({8'd3, 8'hAA, 8'hBB, 8'hCC}, 8'd2);
    beat({8'd5, 8'hAA, 8'hBB, 8'hCC}, 8'd4);
    beat({8'd7, 8'hAA, 8'hBB, 8'hCC}, 8'd6);
    chk("s_in_ready_off", 64'(bif.in_ready), 64'd0);
    chk("s_mul_a3",       64'(bif.mul_a3), 64'd7);
    chk("s_lanes_gated",  64'({bif.mul_a2, bif.mul_a1, bif.mul_a0}), 64'd0);
    chk("s_t1_no_valid",  64'(bif.out_valid), 64'd0);
    tick();
    chk("s_t2_no_valid",  64'(bif.out_valid), 64'd0);
    tick();
    chk("s_t3_valid",     64'(bif.out_valid), 64'd1);
    chk("s_acc",          64'(bif.out_acc), 64'd68);
    chk("s_err",          64'(bif.out_err), 64'd0);
    bif.cfg_valid = 1'b1;
    #1;
    chk("done_cfg_ready", 64'(bif.cfg_ready), 64'd0);
    bif.cfg_valid = 1'b0;
    release_out();
    chk("s_busy_drop",     64'(bif.busy), 64'd0);
    chk("s_cfg_ready_up",  64'(bif.cfg_ready), 64'd1);
    chk("s_valid_drop",    64'(bif.out_valid), 64'd0);

    // QUAD len=2: 0x01020304*2 + 0x10*3 = 0x02040638
    cfg(MAC_QUAD, 16'd2);
    chk("q_mul_cfg0", 64'(bif.mul_cfg), 64'(MAC_QUAD));
    beat(32'h01020304, 8'd2);
    chk("q_mul_a0", 64'(bif.mul_a0), 64'h04);
    beat(32'h00000010, 8'd3);
    wait_out("q_wait");
    chk("q_acc",      64'(bif.out_acc), 64'h02040638);
    chk("q_mul_cfg1", 64'(bif.mul_cfg), 64'(MAC_QUAD));
    release_out();

    // DUAL len=2 with a 2-cycle gap: 2 * 0x01FF*0x10 = 0x3FE0
    cfg(MAC_DUAL, 16'd2);
    beat({8'h01, 8'hFF, 8'h55, 8'h66}, 8'h10);
    chk("d_gap_ready", 64'(bif.in_ready), 64'd1);
    chk("d_lanes_gated", 64'({bif.mul_a1, bif.mul_a0}), 64'd0);
    chk("d_mul_a2", 64'(bif.mul_a2), 64'hFF);
    tick(); tick();
    beat({8'h01, 8'hFF, 8'h55, 8'h66}, 8'h10);
    chk("d_ready_drop", 64'(bif.in_ready), 64'd0);
    wait_out("d_wait");
    chk("d_acc", 64'(bif.out_acc), 64'h3FE0);
    release_out();

    // len=0: result the next cycle, accumulator cleared
    cfg(MAC_SINGLE, 16'd0);
    chk("z_valid", 64'(bif.out_valid), 64'd1);
    chk("z_acc",   64'(bif.out_acc),   64'd0);
    chk("z_err",   64'(bif.out_err),   64'd0);
    release_out();

    // invalid mode: error result next cycle, no beats consumed
    bif.in_valid = 1'b1;
    cfg(2'b11, 16'd5);
    chk("e_valid",    64'(bif.out_valid), 64'd1);
    chk("e_err",      64'(bif.out_err),   64'd1);
    chk("e_acc",      64'(bif.out_acc),   64'd0);
    chk("e_in_ready", 64'(bif.in_ready),  64'd0);
    bif.in_valid = 1'b0;
    release_out();

    // stall: en low 3 cycles mid-RUN; 2*10 + 3*10 + 4*10 = 90, valid at cfg+9
    c0 = cyc;
    cfg(MAC_SINGLE, 16'd3);
    beat({8'd2, 24'h0}, 8'd10);
    en = 1'b0;
    bif.in_valid = 1'b1; bif.in_a = {8'd3, 24'h0}; bif.in_b = 8'd10;
    #1;
    chk("st_in_ready_off", 64'(bif.in_ready), 64'd0);
    tick(); tick(); tick();
    en = 1'b1;
    beat({8'd3, 24'h0}, 8'd10);
    beat({8'd4, 24'h0}, 8'd10);
    tick();
    chk("st_no_valid_early", 64'(bif.out_valid), 64'd0);
    tick();
    chk("st_latency", 64'(cyc - c0), 64'd9);
    chk("st_valid",   64'(bif.out_valid), 64'd1);
    chk("st_acc",     64'(bif.out_acc), 64'd90);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("st_hold_valid", 64'(bif.out_valid), 64'd1);
      chk("st_hold_acc",   64'(bif.out_acc), 64'd90);
    end
    en = 1'b0;
    bif.out_ready = 1'b1;
    tick();
    chk("st_en_off_hold", 64'(bif.out_valid), 64'd1);
    en = 1'b1;
    tick();
    bif.out_ready = 1'b0;
    chk("st_released", 64'(bif.out_valid), 64'd0);

    // reset mid-job abandons it
    cfg(MAC_SINGLE, 16'd4);
    beat({8'd5, 24'h0}, 8'd5);
    beat({8'd5, 24'h0}, 8'd5);
    tick();
    chk("r_acc_partial", 64'(bif.out_acc), 64'd25);
    rst = 1'b1;
    #1;
    chk("r_acc",   64'(bif.out_acc), 64'd0);
    chk("r_busy",  64'(bif.busy), 64'd0);
    chk("r_mul",   64'({bif.mul_a3, bif.mul_b, bif.mul_cfg}), 64'd0);
    chk("r_valid", 64'(bif.out_valid), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    cfg(MAC_SINGLE, 16'd1);
    beat({8'd9, 24'h0}, 8'd9);
    wait_out("r2_wait");
    chk("r2_acc", 64'(bif.out_acc), 64'd81);
    chk("r2_err", 64'(bif.out_err), 64'd0);
    release_out();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
